// File: rtl/sim_uart_cosim_if.sv
// Host-side handshake bundle for sim_uart_cosim: byte TX (valid/ready) and RX strobe.
// master = host/testbench side, slave = the UART endpoint.
interface sim_uart_cosim_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_frame_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_frame_err
  );
endinterface

// File: rtl/sim_uart_cosim.sv
// sim_uart_cosim: UART endpoint for the simulation top. Serialises host bytes from a
// TX FIFO onto dut_uart_rx and deserialises dut_uart_tx into an RX strobe.
// Optional feature: define SIM_UART_PARITY_EN for an even-parity bit in both directions.
module sim_uart_cosim #(
  parameter int unsigned TICKS_PER_BAUD = 4,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sim_uart_cosim_if.slave      host,
  input  logic                 dut_uart_tx,
  output logic                 dut_uart_rx,
  output logic                 uart_sampling,
  output logic [7:0]           uart_ticks_counter,
  output logic [31:0]          uart_ticks_per_baud
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  TICK_LAST = 8'(TICKS_PER_BAUD - 1);
  localparam logic [7:0]  TICK_HALF = 8'(TICKS_PER_BAUD / 2);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef SIM_UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef SIM_UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  // TX FIFO and serialiser state
  logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 fifo_empty, fifo_full, push, pop;
  tx_state_e            tx_state_q, tx_state_d;
  logic [7:0]           tx_tick_q, tx_tick_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic                 tx_stop_q, tx_stop_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_line_q, tx_line_d;
`ifdef SIM_UART_PARITY_EN
  logic                 tx_par_q, tx_par_d;
`endif

  // RX synchroniser and deserialiser state
  logic [1:0]           sync_q;
  logic                 rx_prev_q;
  logic                 rx_line;
  rx_state_e            rx_state_q, rx_state_d;
  logic [7:0]           rx_tick_q, rx_tick_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_err_q, rx_err_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_samp_q, rx_samp_d;
`ifdef SIM_UART_PARITY_EN
  logic                 rx_par_err_q, rx_par_err_d;
`endif

  // FIFO bookkeeping plus TX frame sequencing; IDLE pops the head and drives the start bit next cycle
  always_comb begin
    fifo_empty    = (wr_ptr_q == rd_ptr_q);
    fifo_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop           = (tx_state_q == TX_IDLE) && !fifo_empty;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    host.tx_ready = !fifo_full || pop;
    push          = host.tx_valid && host.tx_ready;
    fifo_mem_d    = fifo_mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q[AW-1:0]] = host.tx_data[DATA_BITS-1:0];
      wr_ptr_d                     = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    tx_state_d = tx_state_q;
    tx_tick_d  = (tx_tick_q == TICK_LAST) ? '0 : tx_tick_q + 8'd1;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
`ifdef SIM_UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        tx_tick_d = '0;
        tx_line_d = 1'b1;
        if (pop) begin
          tx_shift_d = fifo_mem_q[rd_ptr_q[AW-1:0]];
`ifdef SIM_UART_PARITY_EN
          tx_par_d   = ^fifo_mem_q[rd_ptr_q[AW-1:0]];
`endif
          tx_state_d = TX_START;
          tx_line_d  = 1'b0;
        end
      end
      TX_START: if (tx_tick_q == TICK_LAST) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
        tx_line_d  = tx_shift_q[0];
      end
      TX_DATA: if (tx_tick_q == TICK_LAST) begin
        if (tx_bit_q == BIT_LAST) begin
          tx_stop_d = 1'b0;
`ifdef SIM_UART_PARITY_EN
          tx_state_d = TX_PARITY;
          tx_line_d  = tx_par_q;
`else
          tx_state_d = TX_STOP;
          tx_line_d  = 1'b1;
`endif
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = tx_shift_q >> 1;
          tx_line_d  = tx_shift_q[1];
        end
      end
`ifdef SIM_UART_PARITY_EN
      TX_PARITY: if (tx_tick_q == TICK_LAST) begin
        tx_state_d = TX_STOP;
        tx_line_d  = 1'b1;
      end
`endif
      TX_STOP: if (tx_tick_q == TICK_LAST) begin
        if (tx_stop_q == STOP_LAST) tx_state_d = TX_IDLE;
        else                        tx_stop_d  = 1'b1;
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  // TX register stage; a reset mid-frame returns the line high on the next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_mem_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
`ifdef SIM_UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
`ifdef SIM_UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign rx_line = sync_q[1];

  // RX decode: every sample lands where the tick counter equals TICKS_PER_BAUD/2
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = (rx_tick_q == TICK_LAST) ? '0 : rx_tick_q + 8'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_err_d   = rx_err_q;
    rx_valid_d = 1'b0;
    rx_samp_d  = 1'b0;
`ifdef SIM_UART_PARITY_EN
    rx_par_err_d = rx_par_err_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        rx_tick_d = '0;
        if (!rx_line && rx_prev_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_tick_q == TICK_HALF) begin
        rx_samp_d = 1'b1;
        if (rx_line) begin
          rx_state_d = RX_IDLE;
          rx_tick_d  = '0;
        end else begin
          rx_state_d = RX_DATA;
          rx_bit_d   = '0;
        end
      end
      RX_DATA: if (rx_tick_q == TICK_HALF) begin
        rx_samp_d  = 1'b1;
        rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == BIT_LAST) begin
`ifdef SIM_UART_PARITY_EN
          rx_state_d = RX_PARITY;
`else
          rx_state_d = RX_STOP;
`endif
        end else begin
          rx_bit_d = rx_bit_q + 3'd1;
        end
      end
`ifdef SIM_UART_PARITY_EN
      RX_PARITY: if (rx_tick_q == TICK_HALF) begin
        rx_samp_d    = 1'b1;
        rx_par_err_d = rx_line ^ (^rx_shift_q);
        rx_state_d   = RX_STOP;
      end
`endif
      RX_STOP: if (rx_tick_q == TICK_HALF) begin
        rx_samp_d  = 1'b1;
        rx_valid_d = 1'b1;
        rx_data_d  = 8'(rx_shift_q);
`ifdef SIM_UART_PARITY_EN
        rx_err_d   = !rx_line || rx_par_err_q;
`else
        rx_err_d   = !rx_line;
`endif
        if (rx_line) begin
          rx_state_d = RX_IDLE;
          rx_tick_d  = '0;
        end else begin
          rx_state_d = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: if (rx_line) begin
        rx_state_d = RX_IDLE;
        rx_tick_d  = '0;
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_tick_d  = '0;
      end
    endcase
  end

  // RX synchroniser, edge history and registered host/cosim outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q       <= 2'b11;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_err_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_samp_q    <= 1'b0;
`ifdef SIM_UART_PARITY_EN
      rx_par_err_q <= 1'b0;
`endif
    end else begin
      sync_q       <= {sync_q[0], dut_uart_tx};
      rx_prev_q    <= rx_line;
      rx_state_q   <= rx_state_d;
      rx_tick_q    <= rx_tick_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_err_q     <= rx_err_d;
      rx_valid_q   <= rx_valid_d;
      rx_samp_q    <= rx_samp_d;
`ifdef SIM_UART_PARITY_EN
      rx_par_err_q <= rx_par_err_d;
`endif
    end
  end

  assign dut_uart_rx         = tx_line_q;
  assign host.rx_data        = rx_data_q;
  assign host.rx_valid       = rx_valid_q;
  assign host.rx_frame_err   = rx_err_q;
  assign uart_sampling       = rx_samp_q;
  assign uart_ticks_counter  = rx_tick_q;
  assign uart_ticks_per_baud = 32'(TICKS_PER_BAUD);

endmodule
